// File: rtl/act_pack.sv
// act_pack: binarizes FP32 activations, packs bits LSB-first into WORD-bit
// words and buffers complete words in a DEPTH-entry FIFO. Also keeps a
// saturating count of inputs that are not a clean 0.0 / -0.0 / 1.0.
module act_pack #(
    parameter int WORD  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(WORD) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_operand,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WORD-1:0]  out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last,
    output logic [15:0]      nonbin_cnt
);
    localparam int FW = $clog2(WORD);
    localparam int PW = $clog2(DEPTH);
    localparam logic [FW-1:0] FILL_MAX = FW'(WORD - 1);
    localparam logic [PW:0]   OCC_FULL = (PW + 1)'(DEPTH);

    // assembly state
    logic [WORD-1:0]  r_acc;
    logic [FW-1:0]    r_fill;
    logic [15:0]      r_nonbin;

    // FIFO storage; occupancy carries one extra bit so full != empty
    logic [WORD-1:0]  r_mem_data [DEPTH];
    logic [CNT_W-1:0] r_mem_cnt  [DEPTH];
    logic             r_mem_last [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_occ;

    logic             w_accept;
    logic             w_bit;
    logic             w_nonbin;
    logic             w_close;
    logic             w_push;
    logic             w_pop;
    logic [WORD-1:0]  w_word;
    logic [CNT_W-1:0] w_count;

    // Ready only depends on registered occupancy (plus reset), so there is
    // no path from in_* to out_*. Deasserts when full even if the accept
    // would not complete a word.
    assign in_ready  = !rst && (r_occ < OCC_FULL);
    assign w_accept  = in_valid && in_ready;
    assign w_bit     = !in_operand[31] && (in_operand[30:23] != 8'h00);
    assign w_nonbin  = (in_operand != 32'h0000_0000) &&
                       (in_operand != 32'h8000_0000) &&
                       (in_operand != 32'h3F80_0000);
    assign w_close   = (r_fill == FILL_MAX) || in_last;
    assign w_push    = w_accept && w_close;
    assign w_pop     = out_valid && out_ready;
    assign w_count   = CNT_W'(r_fill) + CNT_W'(1);

    // Word as it would look with the incoming bit merged at the fill slot
    always_comb begin
        w_word         = r_acc;
        w_word[r_fill] = w_bit;
    end

    // Accumulator, fill position and non-binary counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_fill   <= '0;
            r_nonbin <= '0;
        end else if (w_accept) begin
            if (w_close) begin
                r_acc  <= '0;
                r_fill <= '0;
            end else begin
                r_acc  <= w_word;
                r_fill <= r_fill + FW'(1);
            end
            if (w_nonbin && (r_nonbin != 16'hFFFF))
                r_nonbin <= r_nonbin + 16'd1;
        end
    end

    // FIFO payload; contents need no reset since out_valid gates the outputs
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= w_word;
            r_mem_cnt[r_wptr]  <= w_count;
            r_mem_last[r_wptr] <= in_last;
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves occupancy as is
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (PW + 1)'(1);
                2'b01:   r_occ <= r_occ - (PW + 1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign out_valid  = (r_occ != '0);
    assign out_data   = out_valid ? r_mem_data[r_rptr] : '0;
    assign out_count  = out_valid ? r_mem_cnt[r_rptr]  : '0;
    assign out_last   = out_valid ? r_mem_last[r_rptr] : 1'b0;
    assign nonbin_cnt = r_nonbin;

endmodule

// File: tb/tb_act_pack.sv
// Randomized bench for act_pack against a queue-based reference model.
module tb_act_pack;
    localparam int WORD  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_operand = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WORD-1:0]  out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_last;
    logic [15:0]      nonbin_cnt;

    act_pack #(.WORD(WORD), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_operand(in_operand), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .out_last(out_last), .nonbin_cnt(nonbin_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      d;
        logic [CNT_W-1:0] c;
        logic             l;
    } wrec_t;

    int    checks = 0;
    int    errors = 0;
    wrec_t exp_q[$];
    wrec_t got_q[$];
    bit    cur_bits[$];
    int    mnb = 0;

    // Reference: element k of a vector lands at bit k; a word closes at 32
    // elements or at in_last.
    task automatic model_accept(input logic [31:0] op, input logic lst);
        wrec_t w;
        real   f;
        bit    b;
        b = (op[31] == 1'b0) && (op[30:23] != 8'd0);
        if (!(op == 32'h0 || op == 32'h80000000 || op == 32'h3F800000))
            mnb = (mnb < 65535) ? mnb + 1 : 65535;
        cur_bits.push_back(b);
        if (cur_bits.size() == WORD || lst) begin
            w.d = 0;
            f = 1.0;
            for (int k = 0; k < cur_bits.size(); k++) begin
                if (cur_bits[k]) w.d = w.d + 32'(longint'(f));
                f = f * 2.0;
            end
            w.c = CNT_W'(cur_bits.size());
            w.l = lst;
            exp_q.push_back(w);
            cur_bits.delete();
        end
    endtask

    // One clock: drive at negedge, sample just before posedge, return at negedge
    task automatic step(input logic v, input logic [31:0] op, input logic lst, input logic ordy);
        wrec_t w;
        in_valid = v; in_operand = op; in_last = lst; out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            w.d = out_data; w.c = out_count; w.l = out_last;
            got_q.push_back(w);
        end
        if (v && in_ready) model_accept(op, lst);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step(1'b0, 32'h0, 1'b0, 1'b0);
        exp_q.delete(); got_q.delete(); cur_bits.delete(); mnb = 0;
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] rbin();
        case ($urandom_range(0, 2))
            0: return 32'h3F800000;
            1: return 32'h00000000;
            default: return 32'h80000000;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        checks++; if ({out_valid, out_data, out_count, out_last} !== '0) begin errors++;
            $display("FAIL reset_outputs got v=%0b d=%h c=%0d l=%0b want all 0", out_valid, out_data, out_count, out_last); end
        checks++; if (nonbin_cnt !== 16'h0) begin errors++; $display("FAIL reset_nonbin got %h want 0", nonbin_cnt); end
        do_reset(1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_full_word();
        do_reset(1);
        for (int i = 0; i < WORD; i++) begin
            if (i == WORD - 1) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %0b want 0", out_valid); end
            end
            step(1'b1, ((i % 4 == 0) || (i % 4 == 3)) ? 32'h3F800000 : 32'h0, 1'b0, 1'b1);
        end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h99999999 || out_count !== 6'd32 || out_last !== 1'b0) begin errors++;
            $display("FAIL full_word got v=%0b d=%h c=%0d l=%0b want 1 99999999 32 0", out_valid, out_data, out_count, out_last); end
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin errors++;
            $display("FAIL full_count got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] != exp_q[0]) begin errors++;
                $display("FAIL full_model got %h/%0d want %h/%0d", got_q[0].d, got_q[0].c, exp_q[0].d, exp_q[0].c); end
        end
    endtask

    task automatic test_partial();
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h3F800000, i == 4, 1'b1);
        for (int i = 0; i < WORD; i++) step(1'b1, rbin(), 1'b0, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (got_q.size() < 1 || got_q[0].d !== 32'h1F || got_q[0].c !== 6'd5 || got_q[0].l !== 1'b1) begin errors++;
            $display("FAIL partial_word got n=%0d d=%h want 0000001f c=5 l=1", got_q.size(), (got_q.size() > 0) ? got_q[0].d : 32'hx); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++;
            $display("FAIL partial_count got %0d want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < got_q.size(); i++) begin
            checks++; if (got_q[i] != exp_q[i]) begin errors++;
                $display("FAIL partial_word%0d got %h/%0d/%0b want %h/%0d/%0b", i, got_q[i].d, got_q[i].c, got_q[i].l, exp_q[i].d, exp_q[i].c, exp_q[i].l); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] head;
        do_reset(1);
        for (int i = 0; i < DEPTH * WORD; i++) begin
            if (i == DEPTH * WORD - 1) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_before got %0b want 1", in_ready); end
            end
            step(1'b1, rbin(), 1'b0, 1'b0);
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %0b want 0", in_ready); end
        head = out_data;
        step(1'b1, 32'h3F800000, 1'b0, 1'b0);
        checks++; if (out_data !== head || head !== exp_q[0].d) begin errors++;
            $display("FAIL bp_stable got %h want %h", out_data, exp_q[0].d); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL bp_single_pop got %0d want 1", got_q.size()); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_freed got %0b want 1", in_ready); end
        for (int t = 0; t < 20 && got_q.size() < DEPTH; t++) step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (got_q.size() != exp_q.size()) begin errors++;
            $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < got_q.size(); i++) begin
            checks++; if (got_q[i] != exp_q[i]) begin errors++;
                $display("FAIL bp_word%0d got %h/%0d want %h/%0d", i, got_q[i].d, got_q[i].c, exp_q[i].d, exp_q[i].c); end
        end
    endtask

    task automatic test_nonbin();
        logic [31:0] vals [4];
        logic [31:0] op;
        vals[0] = 32'h3F800001; vals[1] = 32'hBF800000; vals[2] = 32'h40000000; vals[3] = 32'h80000000;
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1'b1, vals[i], i == 3, 1'b0);
        checks++; if (out_data !== 32'h5 || out_count !== 6'd4 || out_last !== 1'b1) begin errors++;
            $display("FAIL nonbin_bits got d=%h c=%0d l=%0b want 00000005 4 1", out_data, out_count, out_last); end
        checks++; if (nonbin_cnt !== 16'd3) begin errors++; $display("FAIL nonbin_cnt3 got %0d want 3", nonbin_cnt); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 65540; i++) begin
            op = $urandom;
            if (op == 32'h0 || op == 32'h80000000 || op == 32'h3F800000) op = 32'h12345678;
            step(1'b1, op, 1'b0, 1'b1);
            if (i == 65530) begin
                checks++; if (nonbin_cnt !== 16'(mnb)) begin errors++;
                    $display("FAIL nonbin_mid got %0d want %0d", nonbin_cnt, mnb); end
            end
        end
        checks++; if (nonbin_cnt !== 16'hFFFF) begin errors++; $display("FAIL nonbin_sat got %h want ffff", nonbin_cnt); end
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (got_q.size() != exp_q.size()) begin errors++;
            $display("FAIL nonbin_count got %0d want %0d", got_q.size(), exp_q.size()); end
        else begin
            int bad = 0;
            for (int i = 0; i < got_q.size(); i++) if (got_q[i] != exp_q[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL nonbin_stream got %0d bad words want 0", bad); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        for (int i = 0; i < 10; i++) step(1'b1, (i % 2) ? 32'h40400000 : 32'h3F800000, 1'b0, 1'b1);
        do_reset(1);
        for (int i = 0; i < WORD; i++) step(1'b1, 32'h3F800000, 1'b0, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (got_q.size() != 1 || got_q[0].d !== 32'hFFFFFFFF || got_q[0].c !== 6'd32 || got_q[0].l !== 1'b0) begin errors++;
            $display("FAIL rstmid_word got n=%0d d=%h want 1 ffffffff", got_q.size(), (got_q.size() > 0) ? got_q[0].d : 32'hx); end
        checks++; if (nonbin_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_nonbin got %0d want 0", nonbin_cnt); end
    endtask

    task automatic test_back_to_back();
        int drained;
        do_reset(1);
        for (int i = 0; i < 2 * WORD; i++) step(1'b1, rbin(), 1'b0, 1'b0);
        for (int i = 0; i < WORD; i++) step(1'b1, rbin(), 1'b0, i == WORD - 1);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL b2b_pop got %0d want 1", got_q.size()); end
        drained = 0;
        for (int t = 0; t < 8; t++) begin
            if (out_valid) drained++;
            step(1'b0, 32'h0, 1'b0, 1'b1);
        end
        checks++; if (drained != 2) begin errors++; $display("FAIL b2b_occupancy got %0d want 2", drained); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++;
            $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < got_q.size(); i++) begin
            checks++; if (got_q[i] != exp_q[i]) begin errors++;
                $display("FAIL b2b_word%0d got %h want %h", i, got_q[i].d, exp_q[i].d); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_nonbin();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
